// File: rtl/mux_sel_arbiter_pkg.sv
// Shared definitions for the mux select arbiter and the downstream 2:1 data mux.
// Holds the FSM state encoding and the select polarity constants.
package mux_sel_arbiter_pkg;

   localparam int unsigned MAX_HOLD_DEF = 8;
   localparam int unsigned CNT_W_DEF    = 4;

   // Mux select polarity; also used to record which side owned the path last.
   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN_A = 2'd1,
      ST_OWN_B = 2'd2
   } state_e;

   // Select value that routes the given owner state; IDLE keeps the current select.
   function automatic logic sel_for_state(input state_e st, input logic cur_sel);
      logic s;
      s = cur_sel;
      if (st == ST_OWN_A) s = SEL_A;
      if (st == ST_OWN_B) s = SEL_B;
      return s;
   endfunction

endpackage : mux_sel_arbiter_pkg

// File: rtl/mux_sel_arbiter_hold_counter.sv
// Saturating hold counter: counts consecutive cycles the owner keeps the path
// while the other side is waiting; expire flags the last allowed cycle.
module hold_counter #(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);

   logic [CNT_W-1:0] cnt_q;

   // Count only while the competitor waits; stop at LIMIT rather than wrapping.
   always_ff @(posedge clk) begin
      if (!rst_n || clear || !enable) begin
         cnt_q <= '0;
      end else if (cnt_q != LIMIT) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign expire = enable && (cnt_q == LIMIT);

endmodule : hold_counter

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter producing the registered select for a 2:1 data mux.
// Grants are held until release or hold timeout; all outputs are registered.
module mux_sel_arbiter
   import mux_sel_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_a,
   input  logic req_b,
   input  logic done_a,
   input  logic done_b,
   output logic sel,
   output logic grant_a,
   output logic grant_b,
   output logic busy,
   output logic preempt
);

   state_e state_q;
   state_e state_d;
   logic   last_owner_q;
   logic   last_owner_d;
   logic   preempt_d;
   logic   sel_d;

   logic   cnt_en_c;
   logic   cnt_clr_c;
   logic   expire_c;

   // Hold time accrues only while the non-owner is requesting.
   assign cnt_en_c  = ((state_q == ST_OWN_A) && req_b) ||
                      ((state_q == ST_OWN_B) && req_a);
   assign cnt_clr_c = (state_d != state_q);

   hold_counter #(
      .MAX_HOLD (MAX_HOLD),
      .CNT_W    (CNT_W)
   ) u_hold_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (cnt_clr_c),
      .enable (cnt_en_c),
      .expire (expire_c)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_owner_q <= SEL_B;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
      end
   end

   // Next-state and registered-output decode. Release beats timeout.
   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      preempt_d    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (req_a && (!req_b || (last_owner_q == SEL_B))) begin
               state_d = ST_OWN_A;
            end else if (req_b) begin
               state_d = ST_OWN_B;
            end
         end

         ST_OWN_A: begin
            if (done_a || !req_a) begin
               last_owner_d = SEL_A;
               state_d      = req_b ? ST_OWN_B : ST_IDLE;
            end else if (expire_c) begin
               last_owner_d = SEL_A;
               state_d      = ST_OWN_B;
               preempt_d    = 1'b1;
            end
         end

         ST_OWN_B: begin
            if (done_b || !req_b) begin
               last_owner_d = SEL_B;
               state_d      = req_a ? ST_OWN_A : ST_IDLE;
            end else if (expire_c) begin
               last_owner_d = SEL_B;
               state_d      = ST_OWN_A;
               preempt_d    = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      sel_d = sel_for_state(state_d, sel);
   end

   // Output registers, decoded from next state so they change with the grant edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel     <= SEL_A;
         grant_a <= 1'b0;
         grant_b <= 1'b0;
         busy    <= 1'b0;
         preempt <= 1'b0;
      end else begin
         sel     <= sel_d;
         grant_a <= (state_d == ST_OWN_A);
         grant_b <= (state_d == ST_OWN_B);
         busy    <= (state_d != ST_IDLE);
         preempt <= preempt_d;
      end
   end

endmodule : mux_sel_arbiter

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench for mux_sel_arbiter: a behavioural owner/wait model pushes
// expected outputs every edge; an independent monitor pops and compares.
module tb_mux_sel_arbiter;

   localparam int unsigned MAX_HOLD = 8;
   localparam int unsigned CNT_W    = 4;

   typedef struct packed {
      logic sel;
      logic ga;
      logic gb;
      logic busy;
      logic pre;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n, req_a, req_b, done_a, done_b;
   logic sel, grant_a, grant_b, busy, preempt;

   int   checks   = 0;
   int   failures = 0;
   int   cycle    = 0;
   int   dut_pre_cnt = 0;
   exp_t exp_q[$];

   // Model state: owner 0=none 1=A 2=B; wait = edges the owner held while the other requested.
   int   m_owner = 0;
   int   m_last  = 2;
   int   m_wait  = 0;
   logic m_sel   = 1'b0;

   always #5 clk = ~clk;

   mux_sel_arbiter #(
      .MAX_HOLD (MAX_HOLD),
      .CNT_W    (CNT_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_a   (req_a),
      .req_b   (req_b),
      .done_a  (done_a),
      .done_b  (done_b),
      .sel     (sel),
      .grant_a (grant_a),
      .grant_b (grant_b),
      .busy    (busy),
      .preempt (preempt)
   );

   // Reference model: one step per rising edge from the sampled inputs.
   always @(posedge clk) begin
      logic [1:0] rq;
      logic [1:0] dn;
      int         me;
      int         other;
      logic       pre;
      exp_t       e;
      rq  = {req_b, req_a};
      dn  = {done_b, done_a};
      pre = 1'b0;
      cycle++;
      if (!rst_n) begin
         m_owner = 0; m_last = 2; m_wait = 0; m_sel = 1'b0;
      end else if (m_owner == 0) begin
         if (rq[0] && rq[1]) m_owner = (m_last == 1) ? 2 : 1;
         else if (rq[0])     m_owner = 1;
         else if (rq[1])     m_owner = 2;
         m_wait = 0;
      end else begin
         me    = m_owner - 1;
         other = 1 - me;
         if (dn[me] || !rq[me]) begin
            m_last  = m_owner;
            m_owner = rq[other] ? other + 1 : 0;
            m_wait  = 0;
         end else if (rq[other]) begin
            m_wait++;
            if (m_wait == int'(MAX_HOLD)) begin
               m_last  = m_owner;
               m_owner = other + 1;
               m_wait  = 0;
               pre     = 1'b1;
            end
         end else begin
            m_wait = 0;
         end
      end
      if (m_owner != 0) m_sel = (m_owner == 2);
      e.sel  = m_sel;
      e.ga   = (m_owner == 1);
      e.gb   = (m_owner == 2);
      e.busy = (m_owner != 0);
      e.pre  = pre;
      exp_q.push_back(e);
   end

   // Monitor: samples 1 time unit after each edge, pops and compares.
   initial begin
      exp_t e;
      exp_t got;
      forever begin
         @(posedge clk);
         #1;
         got = {sel, grant_a, grant_b, busy, preempt};
         if (preempt === 1'b1) dut_pre_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty cyc=%0d got=%b", cycle, got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               failures++;
               $display("FAIL outputs cyc=%0d {sel,ga,gb,busy,pre} got=%b exp=%b",
                        cycle, got, e);
            end
         end
         checks++;
         if ((grant_a & grant_b) !== 1'b0) begin
            failures++;
            $display("FAIL mutual_excl cyc=%0d grant_a=%b grant_b=%b", cycle, grant_a, grant_b);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d expected finish before time limit", cycle);
      $fatal(1, "watchdog");
   end

   int   pre0;
   int   age;
   int   prev_owner;
   int   k;
   bit   hit;
   logic r;
   logic d;
   logic [1:0] pend;

   task automatic expect_pre_delta(input string name, input int base, input int want);
      checks++;
      if (dut_pre_cnt - base != want) begin
         failures++;
         $display("FAIL %s preempt_pulses got=%0d exp=%0d", name, dut_pre_cnt - base, want);
      end
   endtask

   task automatic go_idle();
      @(negedge clk);
      req_a = 1'b0; req_b = 1'b0; done_a = 1'b0; done_b = 1'b0; rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1; done_a = 1'b0; done_b = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Fairness: both always request, owner releases on its third cycle.
      pre0 = dut_pre_cnt; age = 0; prev_owner = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         done_a = 1'b0; done_b = 1'b0;
         if (m_owner != prev_owner) begin prev_owner = m_owner; age = 1; end
         else age++;
         if (m_owner != 0 && age == 3) begin
            if (m_owner == 1) done_a = 1'b1; else done_b = 1'b1;
            prev_owner = 0;
         end
      end
      expect_pre_delta("fairness", pre0, 0);

      // Timeout: A then B each held past the limit by a waiting competitor.
      go_idle();
      pre0 = dut_pre_cnt;
      req_a = 1'b1;
      @(negedge clk);
      req_b = 1'b1;
      repeat (20) @(negedge clk);
      expect_pre_delta("timeout", pre0, 2);

      // Done arriving on the expiring cycle wins over the timeout.
      go_idle();
      pre0 = dut_pre_cnt; hit = 1'b0;
      req_a = 1'b1;
      @(negedge clk);
      req_b = 1'b1;
      for (int c = 0; c < 40 && !hit; c++) begin
         @(negedge clk);
         if (m_owner == 1 && m_wait == int'(MAX_HOLD) - 1) begin
            done_a = 1'b1; hit = 1'b1;
         end
      end
      checks++;
      if (!hit) begin
         failures++;
         $display("FAIL collision_reach got=0 exp=1 (hold limit cycle not reached)");
      end
      @(negedge clk);
      done_a = 1'b0; req_a = 1'b0;
      repeat (2) @(negedge clk);
      expect_pre_delta("collision", pre0, 0);

      // Spurious done from the non-owner, then owner drops req without done.
      go_idle();
      req_a = 1'b1;
      @(negedge clk);
      done_b = 1'b1;
      @(negedge clk);
      done_b = 1'b0;
      @(negedge clk);
      req_a = 1'b0;
      repeat (3) @(negedge clk);

      // Reset while B owns, then B alone requests again.
      req_b = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Random traffic.
      go_idle();
      pend = 2'b00;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         done_a = 1'b0; done_b = 1'b0;
         rst_n = ($urandom_range(0, 199) != 0);
         for (int s = 0; s < 2; s++) begin
            r = (s == 0) ? req_a : req_b;
            d = 1'b0;
            if (pend[s]) begin
               r = 1'($urandom_range(0, 1));
            end else if (m_owner == s + 1 && r) begin
               k = int'($urandom_range(0, 39));
               if (k < 4)       d = 1'b1;
               else if (k == 4) r = 1'b0;
            end else if (!r) begin
               r = ($urandom_range(0, 3) == 0);
            end else begin
               d = ($urandom_range(0, 15) == 0);
            end
            pend[s] = d && (m_owner == s + 1);
            if (s == 0) begin req_a = r; done_a = d; end
            else        begin req_b = r; done_b = d; end
         end
      end

      go_idle();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mux_sel_arbiter
